ntt_bfly_pipe: RTL

//  Parametrised, fully pipelined radix-2 NTT/INTT butterfly over Z_Q. Per-beat mode select:

---
 rtl/ntt_bfly_pipe_if.sv | 45 ++++
 rtl/ntt_bfly_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ntt_bfly_pipe_if.sv
// rtl/ntt_bfly_pipe_if.sv - valid/ready bundle for the NTT butterfly pipeline
//
// Purpose: groups the input beat, output beat and status signals of
// ntt_bfly_pipe so the block and its neighbours connect through one port.
// slave  : the butterfly side (consumes in_*, produces out_*, range_err)
// master : the driving side (memory read port / write-back)
// Signals:
//   in_valid/in_ready  input handshake
//   in_a/in_b/in_w     operands and twiddle, W bits each
//   in_mode            0 = Cooley-Tukey, 1 = Gentleman-Sande
//   in_half            scale both results by 2^-1 mod Q
//   in_tag             sideband returned with the result
//   out_valid/out_ready output handshake
//   out_x/out_y        results, W bits each
//   out_tag            tag of the current result
//   range_err          sticky out-of-range operand flag
interface ntt_bfly_pipe_if #(
  parameter int W     = 33,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     in_w;
  logic             in_mode;
  logic             in_half;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_x;
  logic [W-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;
  logic             range_err;

  modport slave (
    input  in_valid, in_a, in_b, in_w, in_mode, in_half, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_y, out_tag, range_err
  );

  modport master (
    output in_valid, in_a, in_b, in_w, in_mode, in_half, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_tag, range_err
  );
endinterface

// File: rtl/ntt_bfly_pipe.sv
// rtl/ntt_bfly_pipe.sv - pipelined radix-2 CT/GS butterfly over Z_Q
//
// Purpose: per-beat Cooley-Tukey or Gentleman-Sande butterfly with optional
// halving, fixed latency MUL_STAGES+3 from the accepting edge, global stall.
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous reset, active low
//   bfly_if  ntt_bfly_pipe_if.slave - input beat, output beat, range_err
// Pipeline: S0 input reg -> MUL_STAGES product regs -> Barrett reduce reg
//           -> add/sub reg -> halve/output reg.
module ntt_bfly_pipe #(
  parameter int           W          = 33,
  parameter logic [W-1:0] Q          = 33'h1FFF00001,
  parameter int           MUL_STAGES = 3,
  parameter int           TAG_W      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ntt_bfly_pipe_if.slave bfly_if
);

  localparam int PW2 = 2 * W;
  localparam int PW  = 2 * W + 2;
  // Barrett with k = bit length of Q keeps the estimate within 2 of the true
  // quotient for any product < Q^2, so two conditional subtracts are exact.
  localparam int            QB = $clog2(Q);
  localparam logic [PW-1:0] MU = (PW'(1) << (2 * QB)) / PW'(Q);

  typedef struct packed {
    logic             v;
    logic             mode;
    logic             half;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     aux;  // CT: a, GS: (a+b) mod Q
  } side_t;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return W'(s);
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[W]) d = d + {1'b0, Q};
    return W'(d);
  endfunction

  // Odd values borrow Q to become even before the shift; needs the W+1 bit sum.
  function automatic logic [W-1:0] halve(input logic [W-1:0] r);
    logic [W:0] s;
    s = {1'b0, r} + (r[0] ? {1'b0, Q} : {(W+1){1'b0}});
    return W'(s >> 1);
  endfunction

  logic             adv;
  logic             range_err_q, range_err_d;

  logic             s0_v_q, s0_mode_q, s0_half_q;
  logic [TAG_W-1:0] s0_tag_q;
  logic [W-1:0]     s0_a_q, s0_b_q, s0_w_q;

  side_t            m_side_q [MUL_STAGES];
  logic [PW2-1:0]   m_prod_q [MUL_STAGES];
  side_t            m0_side_d;
  logic [PW2-1:0]   m0_prod_d;
  logic [W-1:0]     mul_l;

  side_t            rd_side_q;
  logic [W-1:0]     rd_t_q, rd_t_d;
  logic [PW-1:0]    br_p, br_q2, br_q3;
  logic [W+1:0]     br_r;

  logic             as_v_q, as_half_q;
  logic [TAG_W-1:0] as_tag_q;
  logic [W-1:0]     as_x_q, as_y_q, as_x_d, as_y_d;

  logic             out_v_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [W-1:0]     out_x_q, out_y_q, out_x_d, out_y_d;

  // A stalled valid output freezes the whole pipe; bubbles never stall.
  assign adv = !(out_v_q && !bfly_if.out_ready);

  assign bfly_if.in_ready  = adv;
  assign bfly_if.out_valid = out_v_q;
  assign bfly_if.out_x     = out_x_q;
  assign bfly_if.out_y     = out_y_q;
  assign bfly_if.out_tag   = out_tag_q;
  assign bfly_if.range_err = range_err_q;

  always_comb begin
    range_err_d = range_err_q;
    if (bfly_if.in_valid && adv &&
        (bfly_if.in_a >= Q || bfly_if.in_b >= Q || bfly_if.in_w >= Q))
      range_err_d = 1'b1;
  end

  // GS does its add/sub here, ahead of the multiplier, so both modes share
  // one multiplier input and the same stage count.
  always_comb begin
    m0_side_d      = '0;
    m0_side_d.v    = s0_v_q;
    m0_side_d.mode = s0_mode_q;
    m0_side_d.half = s0_half_q;
    m0_side_d.tag  = s0_tag_q;
    m0_side_d.aux  = s0_mode_q ? mod_add(s0_a_q, s0_b_q) : s0_a_q;
    mul_l          = s0_mode_q ? mod_sub(s0_a_q, s0_b_q) : s0_b_q;
    m0_prod_d      = PW2'(mul_l) * PW2'(s0_w_q);
  end

  always_comb begin
    br_p  = PW'(m_prod_q[MUL_STAGES-1]);
    br_q2 = (br_p >> (QB - 1)) * MU;
    br_q3 = br_q2 >> (QB + 1);
    br_r  = (W+2)'(br_p - br_q3 * PW'(Q));
    if (br_r >= (W+2)'(Q)) br_r = br_r - (W+2)'(Q);
    if (br_r >= (W+2)'(Q)) br_r = br_r - (W+2)'(Q);
    rd_t_d = W'(br_r);
  end

  // CT finishes with a +/- t; GS already has X in aux and Y is the product.
  always_comb begin
    as_x_d = rd_side_q.mode ? rd_side_q.aux : mod_add(rd_side_q.aux, rd_t_q);
    as_y_d = rd_side_q.mode ? rd_t_q : mod_sub(rd_side_q.aux, rd_t_q);
  end

  always_comb begin
    out_x_d = as_half_q ? halve(as_x_q) : as_x_q;
    out_y_d = as_half_q ? halve(as_y_q) : as_y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
      s0_v_q      <= 1'b0;
      s0_mode_q   <= 1'b0;
      s0_half_q   <= 1'b0;
      s0_tag_q    <= '0;
      s0_a_q      <= '0;
      s0_b_q      <= '0;
      s0_w_q      <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        m_side_q[i] <= '0;
        m_prod_q[i] <= '0;
      end
      rd_side_q <= '0;
      rd_t_q    <= '0;
      as_v_q    <= 1'b0;
      as_half_q <= 1'b0;
      as_tag_q  <= '0;
      as_x_q    <= '0;
      as_y_q    <= '0;
      out_v_q   <= 1'b0;
      out_tag_q <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
    end else begin
      range_err_q <= range_err_d;
      if (adv) begin
        s0_v_q      <= bfly_if.in_valid;
        s0_mode_q   <= bfly_if.in_mode;
        s0_half_q   <= bfly_if.in_half;
        s0_tag_q    <= bfly_if.in_tag;
        s0_a_q      <= bfly_if.in_a;
        s0_b_q      <= bfly_if.in_b;
        s0_w_q      <= bfly_if.in_w;
        m_side_q[0] <= m0_side_d;
        m_prod_q[0] <= m0_prod_d;
        for (int i = 1; i < MUL_STAGES; i++) begin
          m_side_q[i] <= m_side_q[i-1];
          m_prod_q[i] <= m_prod_q[i-1];
        end
        rd_side_q <= m_side_q[MUL_STAGES-1];
        rd_t_q    <= rd_t_d;
        as_v_q    <= rd_side_q.v;
        as_half_q <= rd_side_q.half;
        as_tag_q  <= rd_side_q.tag;
        as_x_q    <= as_x_d;
        as_y_q    <= as_y_d;
        out_v_q   <= as_v_q;
        out_tag_q <= as_tag_q;
        out_x_q   <= out_x_d;
        out_y_q   <= out_y_d;
      end
    end
  end

endmodule
